multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the KGP-RISC datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same control strobes as the combinational opcode decoder (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst), plus PC/IR enables, as per-state timed pulses.
- Waits a fixed block-RAM latency on every memory access and counts retired instructions.

Parameters:
- MEM_LAT, 2, cycles per instruction/data BRAM access (legal range 1..15).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; a low level forces reset state on that edge.
- run  in  1  1 = leave IDLE and execute; 0 = halt at the next instruction boundary.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- br_cond  in  1  branch condition from the ALU flags; sampled in EXEC.
- pc_write  out  1  PC load enable (1-cycle pulse).
- pc_src  out  1  0 = PC+4, 1 = branch/jump target; qualified by pc_write.
- ir_write  out  1  IR load enable (1-cycle pulse).
- mem_read  out  1  BRAM read strobe; held for the whole access.
- mem_write  out  1  BRAM write strobe; held for the whole access.
- i_or_d  out  1  0 = instruction address, 1 = data address.
- reg_write  out  2  00 none, 01 write rd/rt, 10 write link reg31.
- mem_to_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- alu_src  out  2  00 reg, 01 sign-extended imm, 10 shamt.
- reg_dst  out  1  1 = rd, 0 = rt.
- illegal_op  out  1  1-cycle pulse on an undefined opcode.
- busy  out  1  1 in every state except IDLE.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - State = IDLE, wait counter = 0, retired = 0.
  - Every strobe output = 0.
  - Reset mid-access aborts the access; no pc/ir/reg write may fire in the reset cycle.
- Opcode map:
  - 0 = R-ALU, 2 = I-ALU, 8 = SHIFT, 16 = LW, 32 = SW, 48 = BR, 49 = JAL.
  - Every other opcode is illegal.
- IDLE:
  - run=1 -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_read=1, i_or_d=0 for MEM_LAT cycles, counted by wcnt from 0 to MEM_LAT-1.
  - In the cycle where wcnt == MEM_LAT-1: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
- DECODE:
  - 1 cycle, no strobes.
  - Illegal opcode: pulse illegal_op, do not increment retired, -> FETCH (or IDLE if run=0).
  - Legal opcode -> EXEC.
- EXEC (1 cycle):
  - alu_src: 00 for R-ALU/BR, 01 for I-ALU/LW/SW, 10 for SHIFT.
  - BR: pc_write=br_cond, pc_src=1; instruction retires here.
  - JAL: pc_write=1, pc_src=1.
  - Next state: LW/SW -> MEM; BR -> boundary; all others -> WB.
- MEM:
  - i_or_d=1.
  - LW: mem_read=1; SW: mem_write=1. Each held for MEM_LAT cycles.
  - After the access: LW -> WB; SW -> boundary (retires).
- WB (1 cycle):
  - R-ALU: reg_write=01, reg_dst=1.
  - I-ALU, SHIFT, LW: reg_write=01, reg_dst=0.
  - LW additionally sets mem_to_reg=1.
  - JAL: reg_write=10.
  - -> boundary.
- Boundary (retire):
  - retired increments by 1 on the leaving edge, wrapping modulo 2^CNT_W.
  - run=1 -> FETCH; run=0 -> IDLE.
  - run is ignored everywhere except IDLE and the boundary.
- Latency, in cycles from FETCH entry to boundary:
  - R-ALU / I-ALU / SHIFT / JAL = MEM_LAT+3.
  - LW = 2*MEM_LAT+3.
  - SW = 2*MEM_LAT+2.
  - BR = MEM_LAT+2.
- Mutual exclusion: mem_read and mem_write are never both 1; pc_write and ir_write are 1 together only in the last FETCH cycle.
- All outputs are registered or decoded from state only; there is no combinational path from opcode to outputs before DECODE.

Decomposition:
- Shared package kgp_risc_pkg holds:
  - the opcode constants (OP_RALU=0 … OP_JAL=49);
  - the state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB);
  - the reg_write and alu_src code constants.
- One sub-module, mem_wait_cnt: loadable down-counter with a done flag, reused by FETCH and MEM.

Test Plan:
- Reset, then hold for 5 cycles with run=0 -> all strobes 0, busy=0, retired=0.
- MEM_LAT=2, run=1, opcode=0 -> mem_read high for 2 cycles; ir_write+pc_write in cycle 2; reg_write=01 with reg_dst=1 in cycle 5; retired=1 after 5 cycles.
- opcode=16 (LW) -> second mem_read window of 2 cycles with i_or_d=1; WB shows mem_to_reg=1, reg_dst=0; total 7 cycles.
- opcode=32 (SW) -> mem_write=1 for 2 cycles, reg_write never 1; total 6 cycles. Then opcode=48 with br_cond=0 -> no EXEC pc_write; with br_cond=1 -> pc_write=1, pc_src=1.
- opcode=5 (illegal) -> illegal_op pulses for 1 cycle in DECODE; retired unchanged; returns to FETCH.
- Pull rst_n low during the MEM window of an LW -> next cycle state IDLE, all strobes 0, no reg_write; drop run in mid-instruction -> instruction completes, then IDLE.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: opcode constants, control-FSM state encoding,
// instruction classes and the strobe code values used by the sequencer.
package kgp_risc_pkg;

  localparam logic [5:0] OP_RALU  = 6'd0;
  localparam logic [5:0] OP_IALU  = 6'd2;
  localparam logic [5:0] OP_SHIFT = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd16;
  localparam logic [5:0] OP_SW    = 6'd32;
  localparam logic [5:0] OP_BR    = 6'd48;
  localparam logic [5:0] OP_JAL   = 6'd49;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_RALU, C_IALU, C_SHIFT, C_LW, C_SW, C_BR, C_JAL, C_ILL
  } op_class_t;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RDRT = 2'b01;
  localparam logic [1:0] RW_LINK = 2'b10;

  localparam logic [1:0] ALU_REG   = 2'b00;
  localparam logic [1:0] ALU_IMM   = 2'b01;
  localparam logic [1:0] ALU_SHAMT = 2'b10;

  function automatic op_class_t decode_op(input logic [5:0] op);
    op_class_t c;
    case (op)
      OP_RALU:  c = C_RALU;
      OP_IALU:  c = C_IALU;
      OP_SHIFT: c = C_SHIFT;
      OP_LW:    c = C_LW;
      OP_SW:    c = C_SW;
      OP_BR:    c = C_BR;
      OP_JAL:   c = C_JAL;
      default:  c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter timing one block-RAM access; done is high in the
// final cycle of the access (count == 0).
module mem_wait_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int CW = 4;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC datapath,
// producing per-state control strobes and a retired-instruction count.
module multicycle_ctrl
  import kgp_risc_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             br_cond,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic [1:0]       reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src,
  output logic             reg_dst,
  output logic             illegal_op,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_t    state, state_nx, bnd;
  op_class_t op_cls, dec_cls;
  logic      wdone, wload, retire;

  assign dec_cls = decode_op(opcode);
  assign busy    = (state != S_IDLE);
  assign wload   = (state_nx != state) && (state_nx == S_FETCH || state_nx == S_MEM);

  mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wload),
    .done  (wdone)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Instruction class is captured once in DECODE and held for the rest of the instruction
  always_ff @(posedge clk) begin
    if (state == S_DECODE) op_cls <= dec_cls;
  end

  always_comb begin
    state_nx   = state;
    bnd        = run ? S_FETCH : S_IDLE;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = RW_NONE;
    mem_to_reg = 1'b0;
    alu_src    = ALU_REG;
    reg_dst    = 1'b0;
    illegal_op = 1'b0;
    unique case (state)
      S_IDLE: if (run) state_nx = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (wdone) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_ILL) begin
          illegal_op = 1'b1;
          state_nx   = bnd;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_cls)
          C_IALU, C_LW, C_SW: alu_src = ALU_IMM;
          C_SHIFT:            alu_src = ALU_SHAMT;
          default:            alu_src = ALU_REG;
        endcase
        if (op_cls == C_LW || op_cls == C_SW) begin
          state_nx = S_MEM;
        end else if (op_cls == C_BR) begin
          pc_write = br_cond;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_nx = bnd;
        end else begin
          if (op_cls == C_JAL) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (op_cls == C_LW);
        mem_write = (op_cls == C_SW);
        if (wdone) begin
          if (op_cls == C_LW) begin
            state_nx = S_WB;
          end else begin
            retire   = 1'b1;
            state_nx = bnd;
          end
        end
      end
      S_WB: begin
        case (op_cls)
          C_RALU: begin
            reg_write = RW_RDRT;
            reg_dst   = 1'b1;
          end
          C_IALU, C_SHIFT: reg_write = RW_RDRT;
          C_LW: begin
            reg_write  = RW_RDRT;
            mem_to_reg = 1'b1;
          end
          C_JAL:   reg_write = RW_LINK;
          default: reg_write = RW_NONE;
        endcase
        retire   = 1'b1;
        state_nx = bnd;
      end
      default: state_nx = S_IDLE;
    endcase
    // A reset cycle must never let a pending write or access escape
    if (!rst_n) begin
      retire     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = RW_NONE;
      mem_to_reg = 1'b0;
      alu_src    = ALU_REG;
      reg_dst    = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: randomized instruction stream, per-instruction
// expected profiles from a behavioural model, collected and compared by a monitor.
module tb_multicycle_ctrl;

  localparam int ML = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, run, br_cond;
  logic [5:0]    opcode;
  logic          pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
  logic [1:0]    reg_write, alu_src;
  logic          mem_to_reg, reg_dst, illegal_op, busy;
  logic [CW-1:0] retired;
  logic [12:0]   strobes;

  assign strobes = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                    reg_write, mem_to_reg, alu_src, reg_dst, illegal_op};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_LAT(ML), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .br_cond    (br_cond),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .illegal_op (illegal_op),
    .busy       (busy),
    .retired    (retired)
  );

  // Observable profile of one instruction
  typedef struct {
    int cyc; int frd; int ircyc; int irn; int pct; int drd; int dwr;
    int rw; int rwn; int rd; int mtr; int alu; int ill; int viol; int ret;
  } rec_t;

  rec_t expq[$];
  rec_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_ret = 0;
  int   prev_ret = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int op);
    return op == 0 || op == 2 || op == 8 || op == 16 || op == 32 || op == 48 || op == 49;
  endfunction

  function automatic rec_t model(input int op, input bit br, input int ret0);
    rec_t r;
    r = '{default: 0};
    r.frd = ML; r.ircyc = ML; r.irn = 1;
    r.ret = (ret0 + 1) % (1 << CW);
    case (op)
      0:  begin r.cyc = ML + 3; r.rw = 1; r.rwn = 1; r.rd = 1; end
      2:  begin r.cyc = ML + 3; r.rw = 1; r.rwn = 1; r.alu = 1; end
      8:  begin r.cyc = ML + 3; r.rw = 1; r.rwn = 1; r.alu = 2; end
      16: begin r.cyc = 2*ML + 3; r.drd = ML; r.rw = 1; r.rwn = 1; r.mtr = 1; r.alu = 1; end
      32: begin r.cyc = 2*ML + 2; r.dwr = ML; r.alu = 1; end
      48: begin r.cyc = ML + 2; r.pct = br; end
      49: begin r.cyc = ML + 3; r.pct = 1; r.rw = 2; r.rwn = 1; end
      default: begin r.cyc = ML + 1; r.ill = 1; r.ret = ret0; end
    endcase
    return r;
  endfunction

  task automatic finalize();
    rec_t e;
    cur.ret = int'(retired);
    if (expq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_instr: got cycles=%0d, expected no instruction", cur.cyc);
    end else begin
      e = expq.pop_front();
      chk("cycles", cur.cyc, e.cyc);       chk("fetch_rd", cur.frd, e.frd);
      chk("ir_cycle", cur.ircyc, e.ircyc); chk("ir_count", cur.irn, e.irn);
      chk("pc_target", cur.pct, e.pct);    chk("data_rd", cur.drd, e.drd);
      chk("data_wr", cur.dwr, e.dwr);      chk("reg_write", cur.rw, e.rw);
      chk("reg_write_n", cur.rwn, e.rwn);  chk("reg_dst", cur.rd, e.rd);
      chk("mem_to_reg", cur.mtr, e.mtr);   chk("alu_src", cur.alu, e.alu);
      chk("illegal", cur.ill, e.ill);      chk("exclusion", cur.viol, e.viol);
      chk("retired", cur.ret, e.ret);
    end
    cur = '{default: 0};
  endtask

  // Monitor: samples on the falling edge, delimits instructions by retire or illegal_op
  always @(negedge clk) begin
    if (!rst_n) begin
      cur = '{default: 0};
      prev_ret = 0;
    end else begin
      if (int'(retired) != prev_ret) begin
        finalize();
        prev_ret = int'(retired);
      end
      if (busy) begin
        cur.cyc++;
        if (mem_read && !i_or_d) cur.frd++;
        if (mem_read && i_or_d) cur.drd++;
        if (mem_write && i_or_d) cur.dwr++;
        if (ir_write) begin cur.irn++; cur.ircyc = cur.cyc; end
        if (pc_write && pc_src) cur.pct++;
        if (reg_write != 2'b00) begin
          cur.rwn++; cur.rw = int'(reg_write); cur.mtr = int'(mem_to_reg);
          if (reg_write == 2'b01) cur.rd = int'(reg_dst);
        end
        if (cur.cyc == ML + 2) cur.alu = int'(alu_src);
        if (mem_read && mem_write) cur.viol++;
        if (ir_write && !pc_write) cur.viol++;
        if (pc_write && !pc_src && !ir_write) cur.viol++;
        if (mem_write && !i_or_d) cur.viol++;
        if (illegal_op) begin cur.ill = 1; finalize(); end
      end else if (strobes != '0) begin
        cur.viol++;
      end
    end
  end

  // Called one step after the edge that entered FETCH; returns likewise for the next one
  task automatic run_instr(input int op, input bit br, input bit halt);
    rec_t e;
    e = model(op, br, model_ret);
    model_ret = e.ret;
    expq.push_back(e);
    opcode = 6'(op);
    br_cond = br;
    if (halt) run = 1'b0;
    repeat (e.cyc) @(posedge clk);
    #1;
    if (halt) begin
      chk("halt_busy", int'(busy), 0);
      chk("halt_retired", int'(retired), model_ret);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rand_op();
    int legal_ops[7] = '{0, 2, 8, 16, 32, 48, 49};
    int op;
    if ($urandom_range(0, 99) < 85) return legal_ops[$urandom_range(0, 6)];
    do op = int'($urandom_range(0, 63)); while (is_legal(op));
    return op;
  endfunction

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 6'd0; br_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_strobes", int'(strobes), 0);
      chk("idle_retired", int'(retired), 0);
    end

    run = 1'b1;
    @(posedge clk); #1;
    run_instr(0, 0, 0);
    run_instr(16, 0, 0);
    run_instr(32, 0, 0);
    run_instr(48, 0, 0);
    run_instr(48, 1, 0);
    run_instr(5, 0, 0);
    run_instr(49, 0, 0);
    run_instr(2, 1, 0);
    run_instr(8, 1, 1);
    run_instr(63, 0, 1);
    for (int i = 0; i < 60; i++)
      run_instr(rand_op(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));

    // Abort an LW in its data-memory window
    opcode = 6'd16;
    repeat (ML + 2) @(posedge clk);
    #1;
    chk("abort_mem_read", int'(mem_read), 1);
    chk("abort_i_or_d", int'(i_or_d), 1);
    run = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cycle_strobes", int'(strobes), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 0;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_strobes", int'(strobes), 0);
    chk("post_rst_retired", int'(retired), 0);
    repeat (3) @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk); #1;
    run_instr(0, 0, 0);
    run_instr(16, 0, 1);
    run_instr(32, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
